spi_cs_ctrl: RTL and testbench

SPI_CS_CTRL -- requirements
Module: spi_cs_ctrl

---
 rtl/spi_cs_ctrl_if.sv | 41 ++++
 rtl/spi_cs_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spi_cs_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cs_ctrl_if.sv
// Bus bundle for spi_cs_ctrl: host byte stream, downstream byte-level SPI master and chip select.
// o_RX_Count is present only when SPI_CS_RX_COUNT_EN is defined.
interface spi_cs_ctrl_if #(
    parameter int MAX_BYTES_PER_CS = 2
);
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);

    logic [CW-1:0] i_TX_Count;
    logic [7:0]    i_TX_Byte;
    logic          i_TX_DV;
    logic          o_TX_Ready;
    logic          o_RX_DV;
    logic [7:0]    o_RX_Byte;
    logic [7:0]    o_M_TX_Byte;
    logic          o_M_TX_DV;
    logic          i_M_TX_Ready;
    logic          i_M_RX_DV;
    logic [7:0]    i_M_RX_Byte;
    logic          o_SPI_CS_n;
`ifdef SPI_CS_RX_COUNT_EN
    logic [CW-1:0] o_RX_Count;
`endif

    // Controller side
    modport slave (
`ifdef SPI_CS_RX_COUNT_EN
        output o_RX_Count,
`endif
        input  i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
        output o_TX_Ready, o_RX_DV, o_RX_Byte, o_M_TX_Byte, o_M_TX_DV, o_SPI_CS_n
    );

    // Host / environment side
    modport master (
`ifdef SPI_CS_RX_COUNT_EN
        input  o_RX_Count,
`endif
        output i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
        input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_M_TX_Byte, o_M_TX_DV, o_SPI_CS_n
    );
endinterface

// File: rtl/spi_cs_ctrl.sv
// Chip-select sequencer around a byte-level SPI master: CS setup/hold/inactive timing, multi-byte framing.
// Optional o_RX_Count (1-based received byte index) enabled by defining SPI_CS_RX_COUNT_EN.
module spi_cs_ctrl #(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int CS_SETUP_CLKS    = 2,
    parameter int CS_HOLD_CLKS     = 2,
    parameter int CS_INACTIVE_CLKS = 4
) (
    input logic          i_Clk,
    input logic          i_Rst,
    spi_cs_ctrl_if.slave bus
);
    localparam int CW       = $clog2(MAX_BYTES_PER_CS + 1);
    localparam int MAX_CLKS = (CS_SETUP_CLKS > CS_HOLD_CLKS)
                            ? ((CS_SETUP_CLKS > CS_INACTIVE_CLKS) ? CS_SETUP_CLKS : CS_INACTIVE_CLKS)
                            : ((CS_HOLD_CLKS > CS_INACTIVE_CLKS) ? CS_HOLD_CLKS : CS_INACTIVE_CLKS);
    localparam int CNTW     = (MAX_CLKS > 0) ? $clog2(MAX_CLKS + 1) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES_PER_CS);

    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, XFER, WAIT_NEXT, HOLD, INACTIVE} state_t;

    state_t          state, state_next;
    logic [CNTW-1:0] cnt, cnt_next;
    logic [CW-1:0]   remaining, rem_next, rem_dec;
    logic [7:0]      tx_byte, byte_next;
    logic [7:0]      m_tx_byte, m_tx_byte_next;
    logic [7:0]      rx_byte, rx_byte_next;
    logic            cs_n, cs_n_next;
    logic            tx_ready, tx_ready_next;
    logic            m_tx_dv, m_tx_dv_next;
    logic            rx_dv, rx_dv_next;
`ifdef SPI_CS_RX_COUNT_EN
    logic [CW-1:0]   rx_count, rx_count_next;
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            remaining <= '0;
            tx_byte   <= '0;
            m_tx_byte <= '0;
            rx_byte   <= '0;
            cs_n      <= 1'b1;
            tx_ready  <= 1'b0;
            m_tx_dv   <= 1'b0;
            rx_dv     <= 1'b0;
`ifdef SPI_CS_RX_COUNT_EN
            rx_count  <= '0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            remaining <= rem_next;
            tx_byte   <= byte_next;
            m_tx_byte <= m_tx_byte_next;
            rx_byte   <= rx_byte_next;
            cs_n      <= cs_n_next;
            tx_ready  <= tx_ready_next;
            m_tx_dv   <= m_tx_dv_next;
            rx_dv     <= rx_dv_next;
`ifdef SPI_CS_RX_COUNT_EN
            rx_count  <= rx_count_next;
`endif
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        rem_next       = remaining;
        rem_dec        = remaining - CW'(1);
        byte_next      = tx_byte;
        m_tx_byte_next = m_tx_byte;
        rx_byte_next   = rx_byte;
        cs_n_next      = cs_n;
        m_tx_dv_next   = 1'b0;
        rx_dv_next     = 1'b0;
`ifdef SPI_CS_RX_COUNT_EN
        rx_count_next  = rx_count;
`endif
        case (state)
            IDLE: begin
                // tx_ready is still 0 in the first cycle after reset, so that request is dropped
                if (bus.i_TX_DV && tx_ready && bus.i_TX_Count != '0) begin
                    byte_next  = bus.i_TX_Byte;
                    rem_next   = (bus.i_TX_Count > MAX_CNT) ? MAX_CNT : bus.i_TX_Count;
                    cs_n_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = (CS_SETUP_CLKS > 0) ? SETUP : ISSUE;
`ifdef SPI_CS_RX_COUNT_EN
                    rx_count_next = '0;
`endif
                end
            end
            SETUP: begin
                if (int'(cnt) + 1 >= CS_SETUP_CLKS) begin
                    cnt_next   = '0;
                    state_next = ISSUE;
                end else begin
                    cnt_next = cnt + CNTW'(1);
                end
            end
            ISSUE: begin
                if (bus.i_M_TX_Ready) begin
                    m_tx_dv_next   = 1'b1;
                    m_tx_byte_next = tx_byte;
                    state_next     = XFER;
                end
            end
            XFER: begin
                if (bus.i_M_RX_DV) begin
                    rx_dv_next   = 1'b1;
                    rx_byte_next = bus.i_M_RX_Byte;
                    rem_next     = rem_dec;
                    cnt_next     = '0;
`ifdef SPI_CS_RX_COUNT_EN
                    rx_count_next = rx_count + CW'(1);
`endif
                    if (rem_dec != '0) begin
                        state_next = WAIT_NEXT;
                    end else if (CS_HOLD_CLKS > 0) begin
                        state_next = HOLD;
                    end else begin
                        cs_n_next  = 1'b1;
                        state_next = (CS_INACTIVE_CLKS > 0) ? INACTIVE : IDLE;
                    end
                end
            end
            WAIT_NEXT: begin
                if (bus.i_TX_DV) begin
                    byte_next  = bus.i_TX_Byte;
                    state_next = ISSUE;
                end
            end
            HOLD: begin
                if (int'(cnt) + 1 >= CS_HOLD_CLKS) begin
                    cnt_next   = '0;
                    cs_n_next  = 1'b1;
                    state_next = (CS_INACTIVE_CLKS > 0) ? INACTIVE : IDLE;
                end else begin
                    cnt_next = cnt + CNTW'(1);
                end
            end
            INACTIVE: begin
                if (int'(cnt) + 1 >= CS_INACTIVE_CLKS) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNTW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Registered from the next state so ready lines up with IDLE/WAIT_NEXT without a comb path
        tx_ready_next = (state_next == IDLE) || (state_next == WAIT_NEXT);
    end

    assign bus.o_TX_Ready  = tx_ready;
    assign bus.o_RX_DV     = rx_dv;
    assign bus.o_RX_Byte   = rx_byte;
    assign bus.o_M_TX_DV   = m_tx_dv;
    assign bus.o_M_TX_Byte = m_tx_byte;
    assign bus.o_SPI_CS_n  = cs_n;
`ifdef SPI_CS_RX_COUNT_EN
    assign bus.o_RX_Count  = rx_count;
`endif
endmodule

// File: tb/tb_spi_cs_ctrl.sv
// Scoreboard bench for spi_cs_ctrl: stimulus pushes expected master/receive bytes, a monitor pops them.
// Covers o_RX_Count as well when SPI_CS_RX_COUNT_EN is defined.
module tb_spi_cs_ctrl;
    localparam int MAXB    = 2;
    localparam int SETUP_C = 2;
    localparam int HOLD_C  = 2;
    localparam int INACT_C = 4;
    localparam int CW      = $clog2(MAXB + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned mrx_cyc = 0;
    int unsigned rise_cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          mtx_pulses = 0;
    int          cs_rises = 0;
    int          cs_falls = 0;
    logic        prev_cs = 1'b1;

    logic [7:0]    exp_mtx[$];
    logic [7:0]    exp_rx[$];
    logic [CW-1:0] exp_cnt[$];

    spi_cs_ctrl_if #(.MAX_BYTES_PER_CS(MAXB)) bus();

    spi_cs_ctrl #(
        .MAX_BYTES_PER_CS(MAXB),
        .CS_SETUP_CLKS(SETUP_C),
        .CS_HOLD_CLKS(HOLD_C),
        .CS_INACTIVE_CLKS(INACT_C)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Echoing downstream master: answers each byte three cycles after its TX pulse
    initial begin
        logic [7:0] b;
        bus.i_M_RX_DV   = 1'b0;
        bus.i_M_RX_Byte = '0;
        forever begin
            @(negedge clk);
            if (bus.o_M_TX_DV === 1'b1) begin
                b = bus.o_M_TX_Byte;
                repeat (3) @(negedge clk);
                bus.i_M_RX_Byte = b;
                bus.i_M_RX_DV   = 1'b1;
                mrx_cyc         = cyc + 1;
                @(negedge clk);
                bus.i_M_RX_DV   = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a pulse
    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_RX_DV === 1'b1) begin
                if (exp_rx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got o_RX_DV with byte 0x%0h, expected no pulse", bus.o_RX_Byte);
                end else begin
                    check("rx_byte", 32'(bus.o_RX_Byte), 32'(exp_rx.pop_front()));
                    check("rx_latency", 32'(cyc), 32'(mrx_cyc));
`ifdef SPI_CS_RX_COUNT_EN
                    check("rx_count", 32'(bus.o_RX_Count), 32'(exp_cnt.pop_front()));
`endif
                end
            end
            if (bus.o_M_TX_DV === 1'b1) begin
                mtx_pulses++;
                if (exp_mtx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mtx_unexpected: got o_M_TX_DV with byte 0x%0h, expected no pulse", bus.o_M_TX_Byte);
                end else begin
                    check("mtx_byte", 32'(bus.o_M_TX_Byte), 32'(exp_mtx.pop_front()));
                end
            end
            if (bus.o_SPI_CS_n === 1'b1 && prev_cs === 1'b0) begin
                cs_rises++;
                rise_cyc = cyc;
            end
            if (bus.o_SPI_CS_n === 1'b0 && prev_cs === 1'b1) cs_falls++;
            prev_cs = bus.o_SPI_CS_n;
        end
    end

    task automatic send(input logic [7:0] b, input logic [CW-1:0] count,
                        input bit expect_rx, input logic [CW-1:0] idx);
        bus.i_TX_Byte  = b;
        bus.i_TX_Count = count;
        bus.i_TX_DV    = 1'b1;
        exp_mtx.push_back(b);
        if (expect_rx) begin
            exp_rx.push_back(b);
            exp_cnt.push_back(idx);
        end
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int i = 0;
        while (bus.o_TX_Ready !== 1'b1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(bus.o_TX_Ready), 32'd1);
    endtask

    task automatic wait_cs_high(input string name);
        int i = 0;
        while (bus.o_SPI_CS_n !== 1'b1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(bus.o_SPI_CS_n), 32'd1);
    endtask

    task automatic wait_mtx(input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (bus.o_M_TX_DV !== 1'b1 && i < 50);
        check(name, 32'(bus.o_M_TX_DV), 32'd1);
    endtask

    initial begin
        int f0, r0, p0;
        bus.i_TX_DV      = 1'b0;
        bus.i_TX_Byte    = '0;
        bus.i_TX_Count   = '0;
        bus.i_M_TX_Ready = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_cs_n", 32'(bus.o_SPI_CS_n), 32'd1);
        check("rst_tx_ready", 32'(bus.o_TX_Ready), 32'd0);
        check("rst_rx_dv", 32'(bus.o_RX_DV), 32'd0);
        check("rst_rx_byte", 32'(bus.o_RX_Byte), 32'd0);
        check("rst_m_tx_dv", 32'(bus.o_M_TX_DV), 32'd0);
        check("rst_m_tx_byte", 32'(bus.o_M_TX_Byte), 32'd0);
`ifdef SPI_CS_RX_COUNT_EN
        check("rst_rx_count", 32'(bus.o_RX_Count), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", 32'(bus.o_TX_Ready), 32'd1);

        // Two-byte transaction, INACTIVE request ignored, exact hold/inactive timing
        f0 = cs_falls;
        r0 = cs_rises;
        send(8'hA5, CW'(2), 1'b1, CW'(1));
        check("t1_cs_low_after_accept", 32'(bus.o_SPI_CS_n), 32'd0);
        check("t1_ready_low_setup", 32'(bus.o_TX_Ready), 32'd0);
        wait_ready("t1_wait_next_ready");
        check("t1_cs_low_between", 32'(bus.o_SPI_CS_n), 32'd0);
        send(8'h3C, CW'(2), 1'b1, CW'(2));
        wait_cs_high("t1_cs_rise");
        check("t1_hold_clks", 32'(cyc - mrx_cyc), 32'(HOLD_C));
        repeat (2) @(negedge clk);
        bus.i_TX_Byte  = 8'h99;
        bus.i_TX_Count = CW'(1);
        bus.i_TX_DV    = 1'b1;
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
        check("t1_inactive_ready_low", 32'(bus.o_TX_Ready), 32'd0);
        @(negedge clk);
        check("t1_inactive_ready_back", 32'(bus.o_TX_Ready), 32'd1);
        check("t1_inactive_cycles", 32'(cyc - rise_cyc), 32'(INACT_C));
        check("t1_cs_stays_high", 32'(bus.o_SPI_CS_n), 32'd1);
        check("t1_cs_falls", 32'(cs_falls - f0), 32'd1);
        check("t1_cs_rises", 32'(cs_rises - r0), 32'd1);

        // Zero count is ignored
        p0 = mtx_pulses;
        bus.i_TX_Byte  = 8'h55;
        bus.i_TX_Count = '0;
        bus.i_TX_DV    = 1'b1;
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_cs_high", 32'(bus.o_SPI_CS_n), 32'd1);
            check("t2_ready_high", 32'(bus.o_TX_Ready), 32'd1);
            @(negedge clk);
        end
        check("t2_no_mtx", 32'(mtx_pulses - p0), 32'd0);

        // Count 3 clamps to 2; master stall; requests in SETUP and XFER ignored
        p0 = mtx_pulses;
        r0 = cs_rises;
        bus.i_M_TX_Ready = 1'b0;
        send(8'h11, CW'(3), 1'b1, CW'(1));
        bus.i_TX_Byte = 8'hEE;
        bus.i_TX_DV   = 1'b1;
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_stall_no_mtx", 32'(mtx_pulses - p0), 32'd0);
        check("t3_cs_low_stall", 32'(bus.o_SPI_CS_n), 32'd0);
        bus.i_M_TX_Ready = 1'b1;
        wait_mtx("t3_first_mtx");
        bus.i_TX_Byte = 8'hEE;
        bus.i_TX_DV   = 1'b1;
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
        wait_ready("t3_wait_next_ready");
        send(8'h22, CW'(3), 1'b1, CW'(2));
        wait_cs_high("t3_cs_rise");
        @(negedge clk);
        check("t3_two_pulses", 32'(mtx_pulses - p0), 32'd2);
        check("t3_one_rise", 32'(cs_rises - r0), 32'd1);

        // Reset during the first byte aborts the transfer
        wait_ready("t4_ready");
        send(8'h77, CW'(1), 1'b0, CW'(0));
        wait_mtx("t4_mtx");
        rst = 1'b1;
        #1;
        check("t4_cs_high_immediate", 32'(bus.o_SPI_CS_n), 32'd1);
        check("t4_ready_low_in_reset", 32'(bus.o_TX_Ready), 32'd0);
        check("t4_m_tx_dv_cleared", 32'(bus.o_M_TX_DV), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t4_ready_after_release", 32'(bus.o_TX_Ready), 32'd1);
        repeat (6) @(negedge clk);
        check("t4_cs_still_high", 32'(bus.o_SPI_CS_n), 32'd1);

        check("exp_mtx_drained", 32'(exp_mtx.size()), 32'd0);
        check("exp_rx_drained", 32'(exp_rx.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
